obi_load_tracker: RTL

- Multi-outstanding OBI load-bus front end that sits between the load unit and the OBI load bus (ObiLoadbusCfg).
- Accepts tagged load requests and drives the OBI A channel with OBI-compliant hold-until-grant.
- Tracks up to NrEntries outstanding transactions in an in-order ID FIFO.
- Re-tags in-order R-channel responses with the originating trans_id. Flushed transactions are drained silently. This removes the single-entry limit on OBI load buffers.

---
 rtl/obi_load_tracker.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/obi_load_tracker.sv
// Multi-outstanding OBI load front end: issues tagged loads on the A channel, re-tags in-order R beats.
// Latency: A request 1 cycle after accept; R response is a 0-cycle combinational pass-through.
// Backpressure: req_ready_o drops while an A request is pending, when full or on flush; rsp_ready_i gates obi_rready_o for live heads.
module obi_load_tracker #(
    parameter int unsigned NrEntries    = 4,
    parameter int unsigned AddrWidth    = 34,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned TransIdWidth = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [AddrWidth-1:0]              req_addr_i,
    input  logic [DataWidth/8-1:0]            req_be_i,
    input  logic [TransIdWidth-1:0]           req_trans_id_i,
    output logic                              obi_req_o,
    input  logic                              obi_gnt_i,
    output logic [AddrWidth-1:0]              obi_addr_o,
    output logic [DataWidth/8-1:0]            obi_be_o,
    input  logic                              obi_rvalid_i,
    output logic                              obi_rready_o,
    input  logic [DataWidth-1:0]              obi_rdata_i,
    input  logic                              obi_err_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [DataWidth-1:0]              rsp_data_o,
    output logic                              rsp_err_o,
    output logic [TransIdWidth-1:0]           rsp_trans_id_o,
    output logic [$clog2(NrEntries+1)-1:0]    outstanding_o,
    output logic                              idle_o
);

    localparam int unsigned CntWidth = $clog2(NrEntries + 1);
    localparam int unsigned PtrWidth = (NrEntries > 1) ? $clog2(NrEntries) : 1;
    localparam int unsigned BeWidth  = DataWidth / 8;

    typedef enum logic {
        IDLE,
        WAIT_GNT
    } a_state_e;

    a_state_e                  state_q, state_d;
    logic [AddrWidth-1:0]      addr_q;
    logic [BeWidth-1:0]        be_q;
    logic [TransIdWidth-1:0]   tag_q [NrEntries];
    logic [NrEntries-1:0]      kill_q;
    logic [PtrWidth-1:0]       wptr_q, rptr_q;
    logic [CntWidth-1:0]       count_q;

    logic accept;
    logic retire;
    logic head_live;
    logic full;

    // Pointers wrap at NrEntries-1 so non-power-of-two depths work.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(NrEntries - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full   = (count_q == CntWidth'(NrEntries));
    assign accept = req_valid_i && req_ready_o;

    // A-channel state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A-channel next state: a pending request is only released by a grant, flush does not retract it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept)    state_d = WAIT_GNT;
            WAIT_GNT: if (obi_gnt_i) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // A-channel outputs: request is registered state, acceptance only from IDLE with a free slot.
    always_comb begin
        obi_req_o   = (state_q == WAIT_GNT);
        req_ready_o = (state_q == IDLE) && !flush_i && !full && !rst_i;
    end

    // Address/byte-enable capture at accept; held unchanged until the next accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            be_q   <= '0;
        end else if (accept) begin
            addr_q <= req_addr_i;
            be_q   <= req_be_i;
        end
    end

    assign obi_addr_o = addr_q;
    assign obi_be_o   = be_q;

    // R-channel steering: killed heads, an empty FIFO and the flush cycle all drain the beat silently.
    always_comb begin
        head_live      = (count_q != '0) && !kill_q[rptr_q] && !flush_i;
        rsp_valid_o    = head_live && obi_rvalid_i;
        obi_rready_o   = head_live ? rsp_ready_i : 1'b1;
        rsp_data_o     = obi_rdata_i;
        rsp_err_o      = obi_err_i;
        rsp_trans_id_o = tag_q[rptr_q];
        retire         = obi_rvalid_i && obi_rready_o && (count_q != '0);
    end

    // ID FIFO: allocate at accept, retire on R handshake; both may happen in one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < NrEntries; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                tag_q[wptr_q] <= req_trans_id_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (retire) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({accept, retire})
                2'b10:   count_q <= count_q + CntWidth'(1);
                2'b01:   count_q <= count_q - CntWidth'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Kill bits: flush marks every slot; free slots are harmless because a push clears its own bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            kill_q <= '0;
        end else if (flush_i) begin
            kill_q <= '1;
        end else if (accept) begin
            kill_q[wptr_q] <= 1'b0;
        end
    end

    assign outstanding_o = count_q;
    assign idle_o        = (count_q == '0) && (state_q == IDLE);

    // An R beat with nothing outstanding is a bus protocol violation.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(obi_rvalid_i && (count_q == '0)))
                else $error("obi_load_tracker: rvalid with no outstanding load");
        end
    end

endmodule
